// File: rtl/mem_io_bridge_if.sv
// Byte-wide CPU memory port plus the RAM and UART side-band signals of the memory/IO bridge.
// The bridge takes the slave view; the CPU, RAM and UART environment takes the master view.
interface mem_io_bridge_if;
    logic        rdy_in;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_dout;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        program_end;

    modport slave (
        input  rdy_in, cpu_a, cpu_dout, cpu_wr, ram_dout, rx_data, rx_valid, tx_ready,
        output cpu_din, io_buffer_full, ram_a, ram_din, ram_we, rx_pop, tx_data, tx_valid,
               program_end
    );

    modport master (
        output rdy_in, cpu_a, cpu_dout, cpu_wr, ram_dout, rx_data, rx_valid, tx_ready,
        input  cpu_din, io_buffer_full, ram_a, ram_din, ram_we, rx_pop, tx_data, tx_valid,
               program_end
    );
endinterface

// File: rtl/mem_io_bridge.sv
// Memory/IO bridge: decodes CPU accesses into RAM or the IO window, returns read data one
// cycle later, buffers UART output in a tagged TX FIFO and flags program end.
module mem_io_bridge #(
    parameter int TX_DEPTH_LOG = 4,
    parameter int FULL_MARGIN  = 2
) (
    input  logic          clk_in,
    input  logic          rst_in,
    mem_io_bridge_if.slave bus
);
    localparam int DEPTH = 1 << TX_DEPTH_LOG;
    localparam logic [TX_DEPTH_LOG:0] DEPTH_CNT  = (TX_DEPTH_LOG + 1)'(DEPTH);
    localparam logic [TX_DEPTH_LOG:0] FULL_LEVEL = (TX_DEPTH_LOG + 1)'(DEPTH - FULL_MARGIN);

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_RX,
        SEL_CNT0,
        SEL_CNT1,
        SEL_CNT2,
        SEL_CNT3,
        SEL_ZERO
    } sel_t;

    typedef struct packed {
        logic       end_tag;
        logic [7:0] data;
    } tx_entry_t;

    // Address decode
    logic io;
    logic off_rx;
    logic off_cnt;
    logic rd_en;
    logic wr_en;
    logic snap_load;
    logic unused_addr_bits;

    assign io        = (bus.cpu_a[17:16] == 2'b11);
    assign off_rx    = io && (bus.cpu_a[15:0] == 16'h0000);
    assign off_cnt   = io && (bus.cpu_a[15:2] == 14'h0001);
    assign rd_en     = bus.rdy_in & ~bus.cpu_wr;
    assign wr_en     = bus.rdy_in & bus.cpu_wr;
    assign snap_load = rd_en & off_cnt & (bus.cpu_a[1:0] == 2'b00);
    assign unused_addr_bits = ^bus.cpu_a[31:18];

    assign bus.ram_a   = bus.cpu_a[16:0];
    assign bus.ram_din = bus.cpu_dout;
    assign bus.ram_we  = wr_en & ~io;
    assign bus.rx_pop  = rd_en & off_rx & bus.rx_valid;

    // Read-source selection
    sel_t        sel_q;
    sel_t        sel_d;
    logic [7:0]  rx_q;
    logic [31:0] cycle_cnt;
    logic [31:0] snap;
    logic [7:0]  din_mux;

    // NOTE: every signal written in an always_comb gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        sel_d = sel_q;
        if (rd_en) begin
            if (!io) begin
                sel_d = SEL_RAM;
            end else if (off_rx) begin
                sel_d = bus.rx_valid ? SEL_RX : SEL_ZERO;
            end else if (off_cnt) begin
                case (bus.cpu_a[1:0])
                    2'd0:    sel_d = SEL_CNT0;
                    2'd1:    sel_d = SEL_CNT1;
                    2'd2:    sel_d = SEL_CNT2;
                    default: sel_d = SEL_CNT3;
                endcase
            end else begin
                sel_d = SEL_ZERO;
            end
        end
    end

    always_comb begin
        din_mux = 8'h00;
        case (sel_q)
            SEL_RAM:  din_mux = bus.ram_dout;
            SEL_RX:   din_mux = rx_q;
            SEL_CNT0: din_mux = snap[7:0];
            SEL_CNT1: din_mux = snap[15:8];
            SEL_CNT2: din_mux = snap[23:16];
            SEL_CNT3: din_mux = snap[31:24];
            default:  din_mux = 8'h00;
        endcase
    end

    assign bus.cpu_din = din_mux;

    // TX FIFO
    tx_entry_t                 fifo_mem [DEPTH];
    logic [TX_DEPTH_LOG-1:0]   head;
    logic [TX_DEPTH_LOG-1:0]   tail;
    logic [TX_DEPTH_LOG:0]     count;
    logic [TX_DEPTH_LOG:0]     count_next;
    logic                      full_q;
    logic                      end_pending;
    logic                      end_q;
    logic                      push_char;
    logic                      push_end;
    logic                      push;
    logic                      pop;
    tx_entry_t                 head_entry;
    tx_entry_t                 push_entry;

    assign push_char  = wr_en & off_rx & (bus.cpu_dout != 8'h00);
    // The end marker bypasses the zero filter and may be queued only once per program.
    assign push_end   = wr_en & off_cnt & (bus.cpu_a[1:0] == 2'b00) & ~end_pending & ~end_q;
    assign bus.tx_valid = (count != '0);
    assign pop        = bus.tx_valid & bus.tx_ready;
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign push       = (push_char | push_end) & ((count != DEPTH_CNT) | pop);
    assign head_entry = fifo_mem[head];
    assign push_entry = '{end_tag: push_end, data: (push_end ? 8'h00 : bus.cpu_dout)};

    assign bus.tx_data        = bus.tx_valid ? head_entry.data : 8'h00;
    assign bus.io_buffer_full = full_q;
    assign bus.program_end    = end_q;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + (TX_DEPTH_LOG + 1)'(1);
            2'b01:   count_next = count - (TX_DEPTH_LOG + 1)'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: the FIFO storage has no reset; tx_valid gates every read of it, so stale
    // contents are never observed and the array can map onto plain RAM.
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem[tail] <= push_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            full_q      <= 1'b0;
            end_pending <= 1'b0;
            end_q       <= 1'b0;
        end else begin
            if (push) begin
                tail <= tail + TX_DEPTH_LOG'(1);
            end
            if (pop) begin
                head <= head + TX_DEPTH_LOG'(1);
            end
            count  <= count_next;
            full_q <= (count_next >= FULL_LEVEL);
            if (push && push_end) begin
                end_pending <= 1'b1;
            end
            if (pop && head_entry.end_tag) begin
                end_pending <= 1'b0;
                end_q       <= 1'b1;
            end
        end
    end

    // CPU-side state: frozen while rdy_in is low
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sel_q     <= SEL_ZERO;
            rx_q      <= 8'h00;
            cycle_cnt <= 32'h0000_0000;
            snap      <= 32'h0000_0000;
        end else begin
            sel_q <= sel_d;
            if (bus.rdy_in) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (snap_load) begin
                snap <= cycle_cnt;
            end
            if (bus.rx_pop) begin
                rx_q <= bus.rx_data;
            end
        end
    end
endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed self-checking bench for mem_io_bridge: RAM round trip, counter snapshot, RX,
// UART output with back-pressure, end marker and asynchronous reset.
module tb_mem_io_bridge;
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;

    always #5 clk_in = ~clk_in;

    mem_io_bridge_if bus ();

    mem_io_bridge #(
        .TX_DEPTH_LOG(4),
        .FULL_MARGIN (2)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_we     = 0;
    int n_pops   = 0;
    logic expect_end = 1'b0;
    logic [7:0]  tx_exp [$];
    logic [7:0]  rd_exp [$];
    logic [31:0] mcnt;
    logic [7:0]  ram_mem [0:131071];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // RAM with one-cycle read latency
    always @(posedge clk_in) begin
        if (bus.ram_we) ram_mem[bus.ram_a] <= bus.ram_din;
        bus.ram_dout <= ram_mem[bus.ram_a];
    end

    // Reference cycle count, used only to find the snapshot start point
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) mcnt <= 32'd0;
        else if (bus.rdy_in) mcnt <= mcnt + 32'd1;
    end

    always @(posedge clk_in) begin
        if (bus.ram_we) n_we++;
        if (bus.rx_pop) n_pops++;
    end

    // TX scoreboard: each accepted byte must match the oldest expected byte
    always @(negedge clk_in) begin
        if (rst_in && expect_end) begin
            check("program_end_after_marker", bus.program_end, 1);
            expect_end = 1'b0;
        end
        if (rst_in && bus.tx_valid && bus.tx_ready) begin
            if (tx_exp.size() == 0) begin
                check("tx_extra_byte", 32'(tx_exp.size()), 32'd1);
            end else begin
                automatic logic [7:0] e = tx_exp.pop_front();
                check("tx_data", bus.tx_data, e);
                if (e == 8'h00) begin
                    check("program_end_before_marker", bus.program_end, 0);
                    expect_end = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        bus.cpu_wr   = 1'b0;
        bus.cpu_a    = 32'h0003_0010;
        bus.cpu_dout = 8'h00;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [7:0] d);
        bus.cpu_a    = a;
        bus.cpu_dout = d;
        bus.cpu_wr   = 1'b1;
        #1;
        check("ram_we_decode", bus.ram_we, (a[17:16] != 2'b11));
        tick();
        idle();
    endtask

    task automatic cpu_read(input string tag, input logic [31:0] a, input logic [7:0] exp);
        bus.cpu_a  = a;
        bus.cpu_wr = 1'b0;
        rd_exp.push_back(exp);
        tick();
        check(tag, bus.cpu_din, rd_exp.pop_front());
    endtask

    initial begin
        int n0;
        bus.rdy_in   = 1'b1;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        idle();
        #2 rst_in = 1'b0;
        #10;
        check("rst_cpu_din", bus.cpu_din, 8'h00);
        check("rst_full", bus.io_buffer_full, 0);
        check("rst_ram_we", bus.ram_we, 0);
        check("rst_rx_pop", bus.rx_pop, 0);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_program_end", bus.program_end, 0);
        @(negedge clk_in) rst_in = 1'b1;
        tick();

        // Counter snapshot starting at cycle_cnt = 0x1FF
        for (int i = 0; i < 1000 && mcnt != 32'h1FF; i++) tick();
        check("cnt_start_reached", mcnt, 32'h1FF);
        cpu_read("cnt_b0", 32'h0003_0004, 8'hFF);
        cpu_read("cnt_b1", 32'h0003_0005, 8'h01);
        cpu_read("cnt_b2", 32'h0003_0006, 8'h00);
        cpu_read("cnt_b3", 32'h0003_0007, 8'h00);

        // Freeze: five cycles with rdy_in low
        bus.rdy_in   = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h99;
        bus.cpu_a    = 32'h0003_0000;
        #1 check("frz_rx_pop", bus.rx_pop, 0);
        tick();
        check("frz_sel_hold_rx", bus.cpu_din, 8'h00);
        bus.cpu_a = 32'h0003_0004;
        tick();
        check("frz_sel_hold_cnt", bus.cpu_din, 8'h00);
        bus.cpu_a    = 32'h0000_0050;
        bus.cpu_dout = 8'h12;
        bus.cpu_wr   = 1'b1;
        #1 check("frz_ram_we", bus.ram_we, 0);
        repeat (3) tick();
        bus.rdy_in   = 1'b1;
        bus.rx_valid = 1'b0;
        cpu_read("cnt_frozen_b0", 32'h0003_0004, 8'h03);
        cpu_read("cnt_frozen_b1", 32'h0003_0005, 8'h02);
        idle();

        // RAM round trip
        n0 = n_we;
        bus.cpu_a    = 32'h0000_0123;
        bus.cpu_dout = 8'hA5;
        bus.cpu_wr   = 1'b1;
        #1;
        check("ram_we_on_write", bus.ram_we, 1);
        check("ram_a", bus.ram_a, 17'h00123);
        check("ram_din", bus.ram_din, 8'hA5);
        tick();
        idle();
        cpu_read("ram_read", 32'h0000_0123, 8'hA5);
        idle();
        check("ram_we_pulses", 32'(n_we - n0), 32'd1);

        // RX with a byte available, then with none
        n0 = n_pops;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h37;
        bus.cpu_a    = 32'h0003_0000;
        #1 check("rx_pop_pulse", bus.rx_pop, 1);
        tick();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h55;
        check("rx_read", bus.cpu_din, 8'h37);
        idle();
        check("rx_pop_count", 32'(n_pops - n0), 32'd1);
        bus.cpu_a = 32'h0003_0000;
        #1 check("rx_empty_no_pop", bus.rx_pop, 0);
        cpu_read("rx_empty_read", 32'h0003_0000, 8'h00);
        idle();
        check("rx_pop_count_empty", 32'(n_pops - n0), 32'd1);

        // UART out with the zero filter
        bus.tx_ready = 1'b1;
        tx_exp.push_back(8'h41);
        cpu_write(32'h0003_0000, 8'h41);
        cpu_write(32'h0003_0000, 8'h00);
        tx_exp.push_back(8'h42);
        cpu_write(32'h0003_0000, 8'h42);
        repeat (4) tick();
        check("uart_drained", 32'(tx_exp.size()), 32'd0);
        check("uart_tx_idle", bus.tx_valid, 0);

        // Back-pressure, drop when full, push+pop when full
        bus.tx_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tx_exp.push_back(8'(8'h10 + i));
            cpu_write(32'h0003_0000, 8'(8'h10 + i));
            check($sformatf("bp_full_%0d", i), bus.io_buffer_full, (i >= 14));
        end
        cpu_write(32'h0003_0000, 8'h99);
        check("bp_full_after_drop", bus.io_buffer_full, 1);
        bus.tx_ready = 1'b1;
        tx_exp.push_back(8'h77);
        cpu_write(32'h0003_0000, 8'h77);
        check("bp_full_push_pop", bus.io_buffer_full, 1);
        repeat (20) tick();
        check("bp_drained", 32'(tx_exp.size()), 32'd0);
        check("bp_tx_idle", bus.tx_valid, 0);
        check("bp_full_clear", bus.io_buffer_full, 0);

        // End marker behind three queued bytes
        bus.tx_ready = 1'b0;
        tx_exp.push_back(8'h61);
        cpu_write(32'h0003_0000, 8'h61);
        tx_exp.push_back(8'h62);
        cpu_write(32'h0003_0000, 8'h62);
        tx_exp.push_back(8'h63);
        cpu_write(32'h0003_0000, 8'h63);
        tx_exp.push_back(8'h00);
        cpu_write(32'h0003_0004, 8'h55);
        cpu_write(32'h0003_0004, 8'h66);
        check("end_not_yet", bus.program_end, 0);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 50 && !bus.program_end; i++) tick();
        check("end_set", bus.program_end, 1);
        check("end_drained", 32'(tx_exp.size()), 32'd0);
        tick();
        check("end_tx_idle", bus.tx_valid, 0);
        cpu_write(32'h0003_0004, 8'h00);
        check("end_locked", bus.tx_valid, 0);

        // Asynchronous reset mid-queue
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tx_exp.push_back(8'(8'h21 + i));
            cpu_write(32'h0003_0000, 8'(8'h21 + i));
        end
        check("mid_tx_valid", bus.tx_valid, 1);
        #3 rst_in = 1'b0;
        #1;
        check("arst_tx_valid", bus.tx_valid, 0);
        check("arst_program_end", bus.program_end, 0);
        check("arst_tx_data", bus.tx_data, 8'h00);
        tx_exp.delete();
        #3 rst_in = 1'b1;
        bus.tx_ready = 1'b1;
        tick();
        check("post_rst_tx_valid", bus.tx_valid, 0);
        tx_exp.push_back(8'h5A);
        cpu_write(32'h0003_0000, 8'h5A);
        repeat (3) tick();
        check("post_rst_drained", 32'(tx_exp.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
